// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mp_pkg
// Description : Shared constants and types for the sliced multi-precision
//               multiplier output path (digit widths, assembler FSM states,
//               digit+carry pair).
// Revision    : 1.0 - initial release
// ============================================================================
package mp_pkg;

  // Width of one resolved product digit (middle-slice sum field).
  localparam int DIGIT_W = 56;
  // Width of the upper-slice carry field; weight is 2^DIGIT_W of its digit.
  localparam int CARRY_W = 2;

  // Product assembler control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } asm_state_e;

  // One element of the slice result stream.
  typedef struct packed {
    logic [DIGIT_W-1:0] sum;
    logic [CARRY_W-1:0] carry;
  } digit_pair_t;

endpackage : mp_pkg
`default_nettype wire

// File: rtl/mp_carry_resolve.sv
`default_nettype none
// ============================================================================
// Module      : mp_carry_resolve
// Description : Combinational carry resolution for one digit position:
//               digit = in_sum + prev_carry + prop (low DIGIT_W bits), and the
//               bit above becomes the new single-bit propagate.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_carry_resolve #(
  parameter int DIGIT_W = mp_pkg::DIGIT_W,
  parameter int CARRY_W = mp_pkg::CARRY_W
) (
  input  logic [DIGIT_W-1:0] in_sum,
  input  logic [CARRY_W-1:0] prev_carry,
  input  logic               prop,
  output logic [DIGIT_W-1:0] digit,
  output logic               prop_out
);
  import mp_pkg::*;

  // One bit of headroom is enough: (2^DIGIT_W - 1) + 3 + 1 < 2^(DIGIT_W+1).
  logic [DIGIT_W:0] w_acc;

  // Add the incoming sum digit, the carry left by the previous digit and the propagate bit.
  always_comb begin
    w_acc = {1'b0, in_sum} + (DIGIT_W+1)'(prev_carry) + (DIGIT_W+1)'(prop);
  end

  assign digit    = w_acc[DIGIT_W-1:0];
  assign prop_out = w_acc[DIGIT_W];

endmodule : mp_carry_resolve
`default_nettype wire

// File: rtl/mp_product_assembler.sv
`default_nettype none
// ============================================================================
// Module      : mp_product_assembler
// Description : Collects NUM_DIGITS sum/carry digits from the multiplier
//               slices LSD-first, resolves the carries, packs one wide product
//               and offers it on a valid/ready handshake.
//               Optional macro MP_ASM_PROTO_CHECK_EN builds a sticky protocol
//               error flag (err); without it err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_product_assembler #(
  parameter int DIGIT_W    = mp_pkg::DIGIT_W,
  parameter int CARRY_W    = mp_pkg::CARRY_W,
  parameter int NUM_DIGITS = 4,
  // Derived; do not override.
  parameter int PROD_W     = NUM_DIGITS*DIGIT_W + 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] in_sum,
  input  logic [CARRY_W-1:0] in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  prod,
  output logic               err
);
  import mp_pkg::*;

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_DIGIT = CNT_W'(NUM_DIGITS-1);

  asm_state_e           state_q,      state_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [PROD_W-1:0]    prod_q,       prod_d;
  logic                 prop_q,       prop_d;
  logic [CARRY_W-1:0]   prev_carry_q, prev_carry_d;
  logic                 in_ready_q,   in_ready_d;
  logic                 out_valid_q,  out_valid_d;

  logic                 w_accept;
  logic [DIGIT_W-1:0]   w_digit;
  logic                 w_prop;
  logic [2:0]           w_top;

  // in_ready is registered and high exactly while in COLLECT.
  assign w_accept = in_valid & in_ready_q;

  // Final top field: leftover carry of the last digit plus the propagate (max 4).
  assign w_top = 3'(prev_carry_q) + 3'(prop_q);

  mp_carry_resolve #(
    .DIGIT_W (DIGIT_W),
    .CARRY_W (CARRY_W)
  ) u_carry_resolve (
    .in_sum     (in_sum),
    .prev_carry (prev_carry_q),
    .prop       (prop_q),
    .digit      (w_digit),
    .prop_out   (w_prop)
  );

  // Next-state and datapath update for the collect/flush/present sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prod_d       = prod_q;
    prop_d       = prop_q;
    prev_carry_d = prev_carry_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        // in_valid is deliberately ignored here, even alongside en.
        if (en) begin
          state_d      = ST_COLLECT;
          cnt_d        = '0;
          prod_d       = '0;
          prop_d       = 1'b0;
          prev_carry_d = '0;
          in_ready_d   = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (w_accept) begin
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              prod_d[k*DIGIT_W +: DIGIT_W] = w_digit;
            end
          end
          prop_d       = w_prop;
          prev_carry_d = in_carry;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_DIGIT) begin
            state_d    = ST_FLUSH;
            in_ready_d = 1'b0;
          end
        end
      end

      ST_FLUSH: begin
        prod_d[PROD_W-1 -: 3] = w_top;
        state_d               = ST_DONE;
        out_valid_d           = 1'b1;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      prod_q       <= '0;
      prop_q       <= 1'b0;
      prev_carry_q <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prod_q       <= prod_d;
      prop_q       <= prop_d;
      prev_carry_q <= prev_carry_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;

`ifdef MP_ASM_PROTO_CHECK_EN
  logic err_q, err_d;
  logic w_bad_valid;
  logic w_bad_en;

  // Digits are only legal while collecting; start pulses only while idle.
  assign w_bad_valid = in_valid & (state_q != ST_COLLECT);
  assign w_bad_en    = en & (state_q != ST_IDLE);

  // Sticky error flag, cleared only by reset.
  always_comb begin
    err_d = err_q | w_bad_valid | w_bad_en;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule : mp_product_assembler
`default_nettype wire

// File: tb/tb_mp_product_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_product_assembler
// Description : Self-checking bench for mp_product_assembler. The expected
//               product is the plain integer value of the digit stream:
//               sum_k * 2^(k*DW) + carry_k * 2^((k+1)*DW).
//               Honours MP_ASM_PROTO_CHECK_EN for the err expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_product_assembler;
  import mp_pkg::*;

  localparam int DW = 56;
  localparam int CW = 2;
  localparam int ND = 4;
  localparam int PW = ND*DW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sum;
  logic [CW-1:0] in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] prod;
  logic          err;

  int n_cmp = 0;
  int n_mis = 0;

  logic          exp_err;
  digit_pair_t   cur[ND];
  logic [PW-1:0] exp_prod;

  mp_product_assembler #(
    .DIGIT_W    (DW),
    .CARRY_W    (CW),
    .NUM_DIGITS (ND)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Product value implied by the digit stream, as plain wide arithmetic.
  function automatic logic [PW-1:0] model_prod();
    logic [PW-1:0] acc;
    acc = '0;
    for (int k = 0; k < ND; k++) begin
      acc = acc + (PW'(cur[k].sum) << (k*DW)) + (PW'(cur[k].carry) << ((k+1)*DW));
    end
    return acc;
  endfunction

  // Records that the bench has just driven a protocol violation.
  task automatic note_violation();
`ifdef MP_ASM_PROTO_CHECK_EN
    exp_err = 1'b1;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [DW-1:0] s0, s1, s2, s3, input logic [CW-1:0] c);
    cur[0].sum = s0; cur[1].sum = s1; cur[2].sum = s2; cur[3].sum = s3;
    for (int k = 0; k < ND; k++) cur[k].carry = c;
  endtask

  task automatic rand_digits();
    logic [63:0] r;
    for (int k = 0; k < ND; k++) begin
      r = {$urandom(), $urandom()};
      cur[k].sum   = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : r[DW-1:0];
      cur[k].carry = CW'($urandom_range(0, 3));
    end
  endtask

  // Start pulse; optional junk in_valid in the same cycle must be ignored.
  task automatic start_run(input bit junk);
    logic [63:0] r;
    r        = {$urandom(), $urandom()};
    en       = 1'b1;
    in_valid = junk;
    in_sum   = r[DW-1:0];
    step();
    en       = 1'b0;
    in_valid = 1'b0;
    if (junk) note_violation();
  endtask

  task automatic feed_digit(input int k, input int gap);
    repeat (gap) step();
    in_valid = 1'b1;
    in_sum   = cur[k].sum;
    in_carry = cur[k].carry;
    step();
    in_valid = 1'b0;
  endtask

  // Full transaction: start, digits with gaps, latency, backpressure, release.
  task automatic run_prod(input string nm, input int gap, input int bp, input bit junk, input bit en_in_done);
    exp_prod = model_prod();
    start_run(junk);
    check_eq({nm, ".in_ready_collect"}, PW'(in_ready), PW'(1));
    for (int k = 0; k < ND; k++) feed_digit(k, gap);
    check_eq({nm, ".valid_in_flush"}, PW'(out_valid), PW'(0));
    check_eq({nm, ".in_ready_flush"}, PW'(in_ready), PW'(0));
    step();
    check_eq({nm, ".valid_latency"}, PW'(out_valid), PW'(1));
    check_eq({nm, ".prod"}, prod, exp_prod);
    out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      en = en_in_done && (i == 1);
      step();
      if (en) note_violation();
      en = 1'b0;
      check_eq({nm, ".bp_valid"}, PW'(out_valid), PW'(1));
      check_eq({nm, ".bp_prod"}, prod, exp_prod);
      check_eq({nm, ".bp_in_ready"}, PW'(in_ready), PW'(0));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({nm, ".valid_drop"}, PW'(out_valid), PW'(0));
    check_eq({nm, ".in_ready_idle"}, PW'(in_ready), PW'(0));
    check_eq({nm, ".prod_held"}, prod, exp_prod);
    check_eq({nm, ".err"}, PW'(err), PW'(exp_err));
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b0;
    exp_err   = 1'b0;

    // Reset state.
    repeat (2) step();
    check_eq("rst.in_ready", PW'(in_ready), PW'(0));
    check_eq("rst.out_valid", PW'(out_valid), PW'(0));
    check_eq("rst.prod", prod, '0);
    check_eq("rst.err", PW'(err), PW'(0));
    rst_n = 1'b1;
    step();

    // Plain assembly, back-to-back.
    set_digits(56'd1, 56'd2, 56'd3, 56'd4, 2'b00);
    run_prod("plain", 0, 0, 1'b0, 1'b0);
    check_eq("plain.literal", prod, (PW'(4) << 168) | (PW'(3) << 112) | (PW'(2) << 56) | PW'(1));

    // Carry chain with all-ones digits and maximum carries.
    set_digits({DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, 2'b11);
    run_prod("chain", 0, 0, 1'b0, 1'b0);
    check_eq("chain.literal", prod, {3'd4, 56'h3, 56'h3, 56'h2, {DW{1'b1}}});

    // Backpressure with an ignored en pulse in DONE.
    set_digits(56'd1, 56'd2, 56'd3, 56'd4, 2'b00);
    run_prod("bp", 0, 5, 1'b0, 1'b1);

    // Gaps of three idle cycles between digits; junk in_valid with en.
    run_prod("gap", 3, 0, 1'b1, 1'b0);

    // Reset mid-collection.
    set_digits({DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, 2'b11);
    start_run(1'b0);
    feed_digit(0, 0);
    feed_digit(1, 1);
    rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    check_eq("midrst.in_ready", PW'(in_ready), PW'(0));
    check_eq("midrst.out_valid", PW'(out_valid), PW'(0));
    check_eq("midrst.prod", prod, '0);
    check_eq("midrst.err", PW'(err), PW'(0));
    step();
    rst_n = 1'b1;
    step();
    run_prod("after_rst", 0, 1, 1'b0, 1'b0);

    // Stray in_valid in IDLE: ignored by the datapath, flagged when checking is built.
    in_valid = 1'b1;
    in_sum   = 56'hABC;
    step();
    in_valid = 1'b0;
    note_violation();
    check_eq("idle_valid.err", PW'(err), PW'(exp_err));
    check_eq("idle_valid.in_ready", PW'(in_ready), PW'(0));
    set_digits(56'd1, 56'd2, 56'd3, 56'd4, 2'b00);
    run_prod("sticky", 0, 0, 1'b0, 1'b0);

    // Randomised transactions.
    for (int t = 0; t < 24; t++) begin
      rand_digits();
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        note_violation();
      end
      run_prod($sformatf("rnd%0d", t), $urandom_range(0, 2), $urandom_range(0, 3),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_mp_product_assembler
`default_nettype wire
